// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, issues credit-limited word-aligned requests to
// variable-latency instruction memory and buffers in-order responses for decode.
module fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instruction,
    output logic [31:0] out_pc
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [PW-1:0] LAST_PTR = PW'(FIFO_DEPTH - 1);

    logic [31:0]   r_pc;
    logic [CW-1:0] r_outstanding;
    logic [CW-1:0] r_drop_count;
    logic [CW-1:0] r_fifo_count;

    // Address queue: PC of every outstanding request, oldest at r_aq_rd.
    logic [31:0]   r_aq_pc [FIFO_DEPTH];
    logic [PW-1:0] r_aq_wr;
    logic [PW-1:0] r_aq_rd;

    // Instruction buffer handed to decode.
    logic [31:0]   r_fq_instr [FIFO_DEPTH];
    logic [31:0]   r_fq_pc    [FIFO_DEPTH];
    logic [PW-1:0] r_fq_wr;
    logic [PW-1:0] r_fq_rd;

    logic w_credit;
    logic w_req_fire;
    logic w_resp_take;
    logic w_resp_drop;
    logic w_push;
    logic w_pop;
    logic w_unused;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PW'(1);
    endfunction

    assign w_credit = (32'(r_outstanding) + 32'(r_fifo_count)) < FIFO_DEPTH;

    assign imem_req_valid = !rst && !redirect_valid && w_credit;
    assign imem_req_addr  = r_pc;
    assign out_valid      = !rst && !redirect_valid && (r_fifo_count != '0);
    assign out_instruction = r_fq_instr[r_fq_rd];
    assign out_pc          = r_fq_pc[r_fq_rd];

    // A response with nothing outstanding is a protocol error and is ignored.
    assign w_req_fire  = imem_req_valid && imem_req_ready;
    assign w_resp_take = !rst && imem_resp_valid && (r_outstanding != '0);
    assign w_resp_drop = w_resp_take && (r_drop_count != '0);
    assign w_push      = w_resp_take && !w_resp_drop && !redirect_valid;
    assign w_pop       = out_valid && out_ready;

    assign w_unused = ^redirect_pc[1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc          <= {RESET_PC[31:2], 2'b00};
            r_outstanding <= '0;
            r_drop_count  <= '0;
            r_fifo_count  <= '0;
            r_aq_wr       <= '0;
            r_aq_rd       <= '0;
            r_fq_wr       <= '0;
            r_fq_rd       <= '0;
        end else begin
            if (w_req_fire) begin
                r_aq_wr <= ptr_inc(r_aq_wr);
            end
            if (w_resp_take) begin
                r_aq_rd <= ptr_inc(r_aq_rd);
            end
            r_outstanding <= r_outstanding + CW'(w_req_fire) - CW'(w_resp_take);

            if (redirect_valid) begin
                // Every request still in flight is stale; one arriving now is consumed here.
                r_pc         <= {redirect_pc[31:2], 2'b00};
                r_drop_count <= r_outstanding - CW'(w_resp_take);
                r_fifo_count <= '0;
                r_fq_wr      <= '0;
                r_fq_rd      <= '0;
            end else begin
                if (w_req_fire) begin
                    r_pc <= r_pc + 32'd4;
                end
                if (w_resp_drop) begin
                    r_drop_count <= r_drop_count - CW'(1);
                end
                if (w_push) begin
                    r_fq_wr <= ptr_inc(r_fq_wr);
                end
                if (w_pop) begin
                    r_fq_rd <= ptr_inc(r_fq_rd);
                end
                r_fifo_count <= r_fifo_count + CW'(w_push) - CW'(w_pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_req_fire) begin
            r_aq_pc[r_aq_wr] <= r_pc;
        end
        if (w_push) begin
            r_fq_instr[r_fq_wr] <= imem_resp_data;
            r_fq_pc[r_fq_wr]    <= r_aq_pc[r_aq_rd];
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: a latency-randomised in-order memory model plus a program-order
// scoreboard (requests and outputs run sequentially from the last reset/redirect target).
module tb_fetch_stage;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int unsigned DEPTH    = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b1;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_data = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_instruction;
    logic [31:0] out_pc;

    always #5 clk = ~clk;

    fetch_stage #(.RESET_PC(RESET_PC), .FIFO_DEPTH(DEPTH)) dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_instruction (out_instruction),
        .out_pc          (out_pc)
    );

    typedef struct {
        logic [31:0] addr;
        int unsigned due;
        int unsigned epoch;
    } mem_ent_t;

    mem_ent_t    mem_q[$];
    int unsigned cyc = 0;
    int unsigned epoch = 0;
    int unsigned buffered = 0;
    int unsigned last_due = 0;
    int unsigned lat_min = 1;
    int unsigned lat_max = 1;
    logic [31:0] exp_req_pc = RESET_PC;
    logic [31:0] exp_out_pc = RESET_PC;

    logic        tb_rst = 1'b1;
    logic        tb_redir = 1'b0;
    logic [31:0] tb_rpc = '0;
    logic        tb_out_ready = 1'b1;
    logic        tb_req_ready = 1'b1;

    logic        obs_req_valid, obs_req_fire, obs_out_valid, obs_out_fire, obs_resp;
    logic [31:0] obs_req_addr, obs_out_pc, obs_out_instr;

    int unsigned n_checks = 0;
    int unsigned n_pass = 0;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return 32'h0F0F_0037 ^ (a << 3);
    endfunction

    function automatic bit resp_due();
        if (mem_q.size() == 0) return 1'b0;
        return mem_q[0].due <= cyc;
    endfunction

    // One clock: drive at negedge, sample 1ns later, score, then advance to posedge.
    task automatic tick();
        int unsigned outst, buf_n, due;
        logic        resp_now, exp_rv, exp_ov;
        mem_ent_t    e;
        @(negedge clk);
        rst            = tb_rst;
        redirect_valid = tb_redir;
        redirect_pc    = tb_rpc;
        out_ready      = tb_out_ready;
        imem_req_ready = tb_req_ready;
        resp_now       = resp_due();
        imem_resp_valid = resp_now;
        if (resp_now) imem_resp_data = instr_of(mem_q[0].addr);
        else          imem_resp_data = $urandom;
        #1;
        outst = mem_q.size();
        buf_n = buffered;
        obs_req_valid = imem_req_valid;
        obs_req_addr  = imem_req_addr;
        obs_req_fire  = (imem_req_valid === 1'b1) && imem_req_ready;
        obs_out_valid = out_valid;
        obs_out_fire  = (out_valid === 1'b1) && out_ready;
        obs_out_pc    = out_pc;
        obs_out_instr = out_instruction;
        obs_resp      = resp_now;
        exp_rv = !tb_rst && !tb_redir && (outst + buf_n < DEPTH);
        exp_ov = !tb_rst && !tb_redir && (buf_n > 0);

        n_checks++;
        if (obs_req_valid !== exp_rv)
            $display("FAIL req_valid cyc=%0d: got %b expected %b", cyc, obs_req_valid, exp_rv);
        else n_pass++;
        n_checks++;
        if (obs_out_valid !== exp_ov)
            $display("FAIL out_valid cyc=%0d: got %b expected %b", cyc, obs_out_valid, exp_ov);
        else n_pass++;
        if (obs_req_fire) begin
            n_checks++;
            if (obs_req_addr !== exp_req_pc)
                $display("FAIL req_addr cyc=%0d: got %h expected %h", cyc, obs_req_addr, exp_req_pc);
            else n_pass++;
        end
        if (obs_out_fire) begin
            n_checks++;
            if (obs_out_pc !== exp_out_pc)
                $display("FAIL out_pc cyc=%0d: got %h expected %h", cyc, obs_out_pc, exp_out_pc);
            else n_pass++;
            n_checks++;
            if (obs_out_instr !== instr_of(exp_out_pc))
                $display("FAIL out_instr cyc=%0d: got %h expected %h", cyc, obs_out_instr, instr_of(exp_out_pc));
            else n_pass++;
        end

        if (tb_rst) begin
            if (resp_now) void'(mem_q.pop_front());
            epoch++;
            buffered   = 0;
            exp_req_pc = RESET_PC;
            exp_out_pc = RESET_PC;
        end else begin
            if (obs_req_fire) begin
                due = cyc + $urandom_range(lat_max, lat_min);
                if (due <= last_due) due = last_due + 1;
                last_due = due;
                e.addr = exp_req_pc;
                e.due = due;
                e.epoch = epoch;
                mem_q.push_back(e);
                exp_req_pc += 32'd4;
            end
            if (obs_out_fire) begin
                exp_out_pc += 32'd4;
                if (buffered > 0) buffered--;
            end
            if (resp_now) begin
                e = mem_q.pop_front();
                if (e.epoch == epoch && !tb_redir) buffered++;
            end
            if (tb_redir) begin
                epoch++;
                buffered   = 0;
                exp_req_pc = {tb_rpc[31:2], 2'b00};
                exp_out_pc = {tb_rpc[31:2], 2'b00};
            end
        end
        @(posedge clk);
        cyc++;
    endtask

    task automatic test_reset();
        tb_rst = 1'b1;
        tick();
        tick();
        n_checks++;
        if (obs_req_valid !== 1'b0 || obs_out_valid !== 1'b0)
            $display("FAIL reset_outputs: got req_valid=%b out_valid=%b expected 0 0", obs_req_valid, obs_out_valid);
        else n_pass++;
        tb_rst = 1'b0;
        tick();
        n_checks++;
        if (obs_req_valid !== 1'b1 || obs_req_addr !== RESET_PC)
            $display("FAIL reset_first_req: got valid=%b addr=%h expected 1 %h", obs_req_valid, obs_req_addr, RESET_PC);
        else n_pass++;
    endtask

    task automatic test_stream();
        int unsigned n = 0;
        logic [31:0] pcs[2];
        logic [31:0] ins[2];
        for (int i = 0; i < 30 && n < 8; i++) begin
            tick();
            if (obs_out_fire) begin
                if (n < 2) begin
                    pcs[n] = obs_out_pc;
                    ins[n] = obs_out_instr;
                end
                n++;
            end
        end
        n_checks++;
        if (n != 8) $display("FAIL stream_count: got %0d outputs expected 8 within 30 cycles", n);
        else n_pass++;
        n_checks++;
        if (pcs[0] !== 32'h0 || ins[0] !== 32'h0F0F_0037)
            $display("FAIL stream_first: got %h@%h expected 0f0f0037@00000000", ins[0], pcs[0]);
        else n_pass++;
        n_checks++;
        if (pcs[1] !== 32'h4 || ins[1] !== 32'h0F0F_0017)
            $display("FAIL stream_second: got %h@%h expected 0f0f0017@00000004", ins[1], pcs[1]);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        int unsigned nreq = 0;
        int unsigned n = 0;
        logic [31:0] p[2];
        tb_out_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (obs_req_fire) nreq++;
        end
        n_checks++;
        if (nreq > DEPTH) $display("FAIL bp_req_count: got %0d requests expected at most %0d", nreq, DEPTH);
        else n_pass++;
        n_checks++;
        if (obs_req_valid !== 1'b0 || obs_out_valid !== 1'b1)
            $display("FAIL bp_stalled: got req_valid=%b out_valid=%b expected 0 1", obs_req_valid, obs_out_valid);
        else n_pass++;
        tb_out_ready = 1'b1;
        for (int i = 0; i < 8 && n < 2; i++) begin
            tick();
            if (obs_out_fire) begin
                p[n] = obs_out_pc;
                n++;
            end
        end
        n_checks++;
        if (n != 2 || p[1] !== p[0] + 32'd4)
            $display("FAIL bp_drain: got %0d outputs pcs %h %h expected 2 consecutive", n, p[0], p[1]);
        else n_pass++;
    endtask

    task automatic test_mem_stall();
        bit seen = 0;
        tb_redir = 1'b1;
        tb_rpc = 32'h0000_0010;
        tick();
        tb_redir = 1'b0;
        tb_req_ready = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            tick();
            seen = obs_req_valid;
        end
        n_checks++;
        if (!seen) $display("FAIL stall_wait: got no request in 10 cycles expected one at 00000010");
        else n_pass++;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_checks++;
            if (obs_req_valid !== 1'b1 || obs_req_addr !== 32'h10 || obs_out_valid !== 1'b0)
                $display("FAIL stall_hold: got valid=%b addr=%h out_valid=%b expected 1 00000010 0",
                         obs_req_valid, obs_req_addr, obs_out_valid);
            else n_pass++;
        end
        tb_req_ready = 1'b1;
    endtask

    task automatic test_redirect_inflight();
        bit got = 0;
        lat_min = 4;
        lat_max = 4;
        for (int i = 0; i < 20 && mem_q.size() < 2; i++) tick();
        tb_redir = 1'b1;
        tb_rpc = 32'h0000_0103;
        tick();
        tb_redir = 1'b0;
        lat_min = 1;
        lat_max = 2;
        n_checks++;
        if (obs_req_valid !== 1'b0 || obs_out_valid !== 1'b0)
            $display("FAIL redir_cycle: got req_valid=%b out_valid=%b expected 0 0", obs_req_valid, obs_out_valid);
        else n_pass++;
        for (int i = 0; i < 20 && !got; i++) begin
            tick();
            got = obs_req_fire;
        end
        n_checks++;
        if (!got || obs_req_addr !== 32'h100)
            $display("FAIL redir_req: got fired=%b addr=%h expected 1 00000100", got, obs_req_addr);
        else n_pass++;
        got = 0;
        for (int i = 0; i < 30 && !got; i++) begin
            tick();
            got = obs_out_fire;
        end
        n_checks++;
        if (!got || obs_out_pc !== 32'h100 || obs_out_instr !== 32'h0F0F_0837)
            $display("FAIL redir_out: got fired=%b %h@%h expected 0f0f0837@00000100", got, obs_out_instr, obs_out_pc);
        else n_pass++;
    endtask

    task automatic test_redirect_coincident();
        bit found = 0;
        bit got = 0;
        lat_min = 1;
        lat_max = 1;
        for (int i = 0; i < 30 && !found; i++) begin
            if (resp_due() && buffered > 0) found = 1;
            else tick();
        end
        n_checks++;
        if (!found) $display("FAIL coinc_setup: got no response+output cycle in 30 cycles expected one");
        else n_pass++;
        tb_redir = 1'b1;
        tb_rpc = 32'h0000_0300;
        tick();
        tb_redir = 1'b0;
        n_checks++;
        if (obs_out_valid !== 1'b0 || obs_req_valid !== 1'b0)
            $display("FAIL coinc_cycle: got out_valid=%b req_valid=%b expected 0 0", obs_out_valid, obs_req_valid);
        else n_pass++;
        for (int i = 0; i < 20 && !got; i++) begin
            tick();
            got = obs_out_fire;
        end
        n_checks++;
        if (!got || obs_out_pc !== 32'h300)
            $display("FAIL coinc_out: got fired=%b pc=%h expected 1 00000300", got, obs_out_pc);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        bit got = 0;
        lat_min = 2;
        lat_max = 3;
        for (int i = 0; i < 4; i++) tick();
        tb_redir = 1'b1;
        tb_rpc = 32'h0000_0400;
        tick();
        tb_rpc = 32'h0000_0504;
        tick();
        tb_redir = 1'b0;
        for (int i = 0; i < 30 && !got; i++) begin
            tick();
            got = obs_out_fire;
        end
        n_checks++;
        if (!got || obs_out_pc !== 32'h504)
            $display("FAIL b2b_redirect: got fired=%b pc=%h expected 1 00000504", got, obs_out_pc);
        else n_pass++;
    endtask

    task automatic reset_and_drain();
        tb_rst = 1'b1;
        tick();
        for (int i = 0; i < 20 && mem_q.size() > 0; i++) tick();
        n_checks++;
        if (obs_req_valid !== 1'b0 || obs_out_valid !== 1'b0)
            $display("FAIL rst_outputs: got req_valid=%b out_valid=%b expected 0 0", obs_req_valid, obs_out_valid);
        else n_pass++;
        tb_rst = 1'b0;
    endtask

    task automatic test_wrap_reset();
        bit got = 0;
        lat_min = 1;
        lat_max = 1;
        tb_redir = 1'b1;
        tb_rpc = 32'hFFFF_FFFE;
        tick();
        tb_redir = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            tick();
            got = obs_req_fire;
        end
        n_checks++;
        if (!got || obs_req_addr !== 32'hFFFF_FFFC)
            $display("FAIL wrap_last: got fired=%b addr=%h expected 1 fffffffc", got, obs_req_addr);
        else n_pass++;
        got = 0;
        for (int i = 0; i < 10 && !got; i++) begin
            tick();
            got = obs_req_fire;
        end
        n_checks++;
        if (!got || obs_req_addr !== 32'h0)
            $display("FAIL wrap_next: got fired=%b addr=%h expected 1 00000000", got, obs_req_addr);
        else n_pass++;
        lat_min = 6;
        lat_max = 6;
        for (int i = 0; i < 20 && mem_q.size() < 2; i++) tick();
        reset_and_drain();
        lat_min = 1;
        lat_max = 1;
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            tick();
            got = obs_out_fire;
        end
        n_checks++;
        if (!got || obs_out_pc !== RESET_PC || obs_out_instr !== 32'h0F0F_0037)
            $display("FAIL rst_first_out: got fired=%b %h@%h expected 0f0f0037@%h", got, obs_out_instr, obs_out_pc, RESET_PC);
        else n_pass++;
    endtask

    task automatic test_random();
        int unsigned nout = 0;
        lat_min = 1;
        lat_max = 4;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(199, 0) == 0) begin
                reset_and_drain();
            end else begin
                tb_out_ready = ($urandom_range(3, 0) != 0);
                tb_req_ready = ($urandom_range(3, 0) != 0);
                tb_redir     = ($urandom_range(19, 0) == 0);
                tb_rpc       = $urandom;
                tick();
                if (obs_out_fire) nout++;
            end
        end
        tb_redir = 1'b0;
        tb_out_ready = 1'b1;
        tb_req_ready = 1'b1;
        n_checks++;
        if (nout < 20) $display("FAIL random_progress: got %0d outputs expected at least 20", nout);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_mem_stall();
        test_redirect_inflight();
        test_redirect_coincident();
        test_back_to_back();
        test_wrap_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction fetch stage of the RV32I core, directly upstream of decode.
- Owns the PC and issues word-aligned requests to instruction memory, which has variable latency.
- Buffers in-order responses in a small FIFO and hands {instruction, pc} to decode over a valid/ready handshake.
- On a redirect (branch/jump resolved later in the pipeline), drops all stale in-flight and buffered instructions.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset; low 2 bits must be 0.
FIFO_DEPTH, 2, instruction buffer entries; outstanding requests plus buffered entries never exceed this value.

Ports:
clk  input  1  single clock; all state updates on posedge.
rst  input  1  synchronous, active-high reset.
imem_req_valid  output  1  fetch request valid.
imem_req_ready  input  1  memory accepts request this cycle.
imem_req_addr  output  32  request byte address, always word-aligned.
imem_resp_valid  input  1  response data valid; responses return in request order.
imem_resp_data  input  32  fetched instruction word.
redirect_valid  input  1  pipeline redirect request.
redirect_pc  input  32  new PC; bits [1:0] are ignored and treated as 0.
out_valid  output  1  instruction available to decode.
out_ready  input  1  decode accepts instruction.
out_instruction  output  32  instruction word for decode.
out_pc  output  32  address of out_instruction.

Behaviour:
- Reset state (rst=1 at a posedge): pc=RESET_PC, FIFO empty, outstanding=0, drop_count=0.
- While rst is high, imem_req_valid=0 and out_valid=0. A mid-operation reset discards everything, including in-flight responses. Responses arriving while rst=1 are ignored.
- Credit rule: imem_req_valid = !rst && !redirect_valid && (outstanding + fifo_count < FIFO_DEPTH).
- imem_req_addr = pc. It is held stable while imem_req_valid=1 and imem_req_ready=0.
- Request handshake (valid && ready): pc <= pc + 4 with 32-bit wrap (32'hFFFF_FFFC -> 32'h0000_0000); outstanding += 1.
- Response handling:
  - If drop_count>0: discard the response; drop_count -= 1; outstanding -= 1.
  - Otherwise: push {imem_resp_data, pc_of_that_request} into the FIFO; outstanding -= 1.
  - Request PCs are tracked in a FIFO_DEPTH-entry in-order address queue.
- Request acceptance and response return in the same cycle both take effect; net outstanding is unchanged.
- Output: out_valid = !rst && !redirect_valid && FIFO non-empty; out_instruction/out_pc come from the FIFO head. Pop on out_valid && out_ready.
- Response-to-out_valid latency is exactly 1 cycle; there is no combinational bypass.
- Push and pop in the same cycle are both performed; fifo_count is unchanged.
- FIFO full cannot overflow, because the credit rule reserves a slot per outstanding request. A response with outstanding=0 is a protocol error (bench assertion); the RTL ignores it.
- Redirect (redirect_valid=1), highest priority below rst:
  - pc <= {redirect_pc[31:2], 2'b00}.
  - FIFO flushed. No request or output handshake occurs this cycle.
  - drop_count <= outstanding, minus 1 if a response also arrives this cycle (that response is discarded).
  - The first request at the new PC issues the following cycle.
- Back-to-back redirects: the last one wins; drop_count is recomputed from the current outstanding each time.
- Drop accounting: drop_count <= FIFO_DEPTH always holds.

Test Plan:
- Reset then stream: rst high 1 cycle, memory returns 0x0F0F_0037 @0x0, 0x0F0F_0017 @0x4 with 1-cycle latency, out_ready=1 -> requests at 0x0, 0x4, 0x8...; out yields (0x0F0F_0037, pc 0x0) then (0x0F0F_0017, pc 0x4), in order, no gaps once steady.
- Backpressure: out_ready=0 for 10 cycles -> at most FIFO_DEPTH=2 requests issued, imem_req_valid drops to 0; on out_ready=1, both instructions drain in order with no loss or duplication.
- Memory stall: imem_req_ready=0 for 5 cycles at pc 0x10 -> imem_req_addr stays 0x10, pc does not advance, out_valid=0 once the FIFO drains.
- Redirect with 2 in flight: redirect_pc=0x0000_0103 while 2 requests are outstanding -> both stale responses dropped; next request addr 0x100; first out_pc=0x100.
- Redirect coincident with response and out handshake: no pop, response discarded, drop_count=outstanding-1, out_valid=0 that cycle.
- Wrap and mid-op reset: pc 0xFFFF_FFFC request accepted -> next addr 0x0; assert rst with 2 outstanding -> late responses ignored, first output after reset is pc=RESET_PC.
